// File: rtl/switch_arbiter.sv
// Round-robin wormhole switch allocator and crossbar slice for one output
// direction of a five-port NoC router (inputs L, N, E, W, S = 0..4).
module switch_arbiter #(
   parameter int FLIT_WIDTH = 34
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Lreq,
   input  logic                  Nreq,
   input  logic                  Ereq,
   input  logic                  Wreq,
   input  logic                  Sreq,
   input  logic [FLIT_WIDTH-1:0] Lflit,
   input  logic [FLIT_WIDTH-1:0] Nflit,
   input  logic [FLIT_WIDTH-1:0] Eflit,
   input  logic [FLIT_WIDTH-1:0] Wflit,
   input  logic [FLIT_WIDTH-1:0] Sflit,
   input  logic                  out_full,
   output logic                  Lgrant,
   output logic                  Ngrant,
   output logic                  Egrant,
   output logic                  Wgrant,
   output logic                  Sgrant,
   output logic [FLIT_WIDTH-1:0] flit_out,
   output logic                  flit_valid,
   output logic                  busy
);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] LOCKED    = 1'b1;
   localparam logic [1:0] TYPE_HEAD = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b01;

   logic [4:0]            req_s;
   logic [FLIT_WIDTH-1:0] flit_s [5];
   logic [4:0]            grant_s;
   logic [2:0]            sel_s;
   logic [3:0]            idx_s;
   logic                  found_s;
   logic                  xfer_s;
   logic [1:0]            sel_type_s;

   logic [0:0]            state_q, state_d;
   logic [2:0]            owner_q, owner_d;
   logic [2:0]            rr_ptr_q, rr_ptr_d;
   logic [FLIT_WIDTH-1:0] flit_out_q, flit_out_d;
   logic                  flit_valid_q, flit_valid_d;
   logic                  busy_q, busy_d;

   assign req_s     = {Sreq, Wreq, Ereq, Nreq, Lreq};
   assign flit_s[0] = Lflit;
   assign flit_s[1] = Nflit;
   assign flit_s[2] = Eflit;
   assign flit_s[3] = Wflit;
   assign flit_s[4] = Sflit;

   // Winner selection: owner while locked, else round-robin over head/single flits.
   always_comb begin
      sel_s   = owner_q;
      found_s = 1'b0;
      idx_s   = 4'd0;
      if (state_q == LOCKED) begin
         found_s = req_s[owner_q];
      end else begin
         for (int k = 1; k <= 5; k++) begin
            idx_s = {1'b0, rr_ptr_q} + 4'(k);
            idx_s = (idx_s >= 4'd5) ? (idx_s - 4'd5) : idx_s;
            if (!found_s && req_s[idx_s[2:0]] && flit_s[idx_s[2:0]][FLIT_WIDTH-1]) begin
               found_s = 1'b1;
               sel_s   = idx_s[2:0];
            end else begin
               found_s = found_s;
            end
         end
      end
      xfer_s     = found_s & ~out_full & rst;
      sel_type_s = flit_s[sel_s][FLIT_WIDTH-1 -: 2];
      grant_s    = 5'b00000;
      if (xfer_s) begin
         grant_s[sel_s] = 1'b1;
      end else begin
         grant_s = 5'b00000;
      end
   end

   // Next-state: lock on a head, release on the owner's tail, capture the flit.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      busy_d       = busy_q;
      flit_out_d   = flit_out_q;
      flit_valid_d = 1'b0;
      if (xfer_s) begin
         flit_out_d   = flit_s[sel_s];
         flit_valid_d = 1'b1;
         case (state_q)
            IDLE: begin
               rr_ptr_d = sel_s;
               if (sel_type_s == TYPE_HEAD) begin
                  state_d = LOCKED;
                  owner_d = sel_s;
                  busy_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            LOCKED: begin
               if (sel_type_s == TYPE_TAIL) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = LOCKED;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end else begin
         flit_valid_d = 1'b0;
      end
   end

   // State and output registers; rr_ptr resets to S so that L has first priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= 3'd0;
         rr_ptr_q     <= 3'd4;
         flit_out_q   <= '0;
         flit_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         flit_out_q   <= flit_out_d;
         flit_valid_q <= flit_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign Lgrant     = grant_s[0];
   assign Ngrant     = grant_s[1];
   assign Egrant     = grant_s[2];
   assign Wgrant     = grant_s[3];
   assign Sgrant     = grant_s[4];
   assign flit_out   = flit_out_q;
   assign flit_valid = flit_valid_q;
   assign busy       = busy_q;

endmodule
